// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op codes and FSM state type for seq_shifter
// Contents: OP_* op code localparams (3 bits), state_t {IDLE, SHIFT, DONE}.
package shifter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;
  localparam logic [OP_W-1:0] OP_ASL = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
// Ports:
//   i_val  in  WIDTH  current working value
//   i_op   in  3      latched op code
//   o_val  out WIDTH  value after one single-bit step
//   o_ovf  out 1      overflow produced by this step (SLL/ASL only)
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_val,
  output logic             o_ovf
);

  always_comb begin
    o_val = i_val;
    o_ovf = 1'b0;
    case (i_op)
      OP_SLL: begin
        o_val = {i_val[WIDTH-2:0], 1'b0};
        o_ovf = i_val[WIDTH-1];
      end
      OP_SRL: o_val = {1'b0, i_val[WIDTH-1:1]};
      OP_SRA: o_val = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
      OP_ROL: o_val = {i_val[WIDTH-2:0], i_val[WIDTH-1]};
      OP_ROR: o_val = {i_val[0], i_val[WIDTH-1:1]};
      OP_ASL: begin
        o_val = {i_val[WIDTH-2:0], 1'b0};
        // The new MSB is the old bit WIDTH-2, so the sign flips iff they differ.
        o_ovf = i_val[WIDTH-1] ^ i_val[WIDTH-2];
      end
      default: begin
        o_val = i_val;
        o_ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shift/rotate unit, one bit position per clock
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      asynchronous active-high reset
//   start  in  1      request, sampled when not busy
//   op     in  3      op code, captured with start
//   din    in  WIDTH  operand, captured with start
//   amt    in  AMT_W  shift amount, captured with start
//   busy   out 1      high while shifting
//   done   out 1      one-cycle pulse when dout/ovf are valid
//   dout   out WIDTH  result, held until next accepted start
//   ovf    out 1      sticky overflow for the current result
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic [AMT_W-1:0] w_amt;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [OP_W-1:0]  r_op;
  logic             r_ovf;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_ovf;

  // Only a non-power-of-two WIDTH lets amt encode values past WIDTH-1.
  generate
    if ((1 << AMT_W) > WIDTH) begin : g_clamp
      assign w_amt = (amt > AMT_W'(WIDTH - 1)) ? AMT_W'(WIDTH - 1) : amt;
    end else begin : g_noclamp
      assign w_amt = amt;
    end
  endgenerate

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_val(r_work),
    .i_op (r_op),
    .o_val(w_step_val),
    .o_ovf(w_step_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // IDLE and DONE behave identically: both accept a start.
  always_comb begin
    w_accept     = 1'b0;
    w_next_state = r_state;
    case (r_state)
      SHIFT: begin
        if (r_cnt == AMT_W'(1)) begin
          w_next_state = DONE;
        end
      end
      default: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = (w_amt != '0) ? SHIFT : DONE;
        end else begin
          w_next_state = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_op   <= OP_SLL;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= w_amt;
      r_work <= din;
      r_op   <= op;
      r_ovf  <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_cnt  <= r_cnt - AMT_W'(1);
      r_work <= w_step_val;
      r_ovf  <= r_ovf | w_step_ovf;
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign dout = r_work;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter (WIDTH=8)
module tb_seq_shifter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] din;
  logic [2:0] amt;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       ovf;

  int n_vec;
  int n_err;

  seq_shifter #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .din  (din),
    .amt  (amt),
    .busy (busy),
    .done (done),
    .dout (dout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Whole-operation reference: result of shifting by a in one go.
  function automatic void model(input logic [2:0] m_op, input logic [7:0] d, input int a,
                                output logic [7:0] r, output bit o);
    int x;
    int s;
    int win;
    x = int'(d);
    r = d;
    o = 1'b0;
    case (m_op)
      3'd0: begin r = 8'(x << a); o = ((x >> (8 - a)) != 0); end
      3'd1: r = 8'(x >> a);
      3'd2: begin s = d[7] ? x - 256 : x; r = 8'(s >>> a); end
      3'd3: r = 8'((x << a) | (x >> (8 - a)));
      3'd4: r = 8'((x >> a) | (x << (8 - a)));
      3'd5: begin
        r   = 8'(x << a);
        win = x >> (7 - a);
        o   = !(win == 0 || win == ((1 << (a + 1)) - 1));
      end
      default: begin r = d; o = 1'b0; end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] t_op, input logic [7:0] t_din, input logic [2:0] t_amt,
                        input logic [7:0] exp_d, input bit exp_o);
    int cyc;
    bit seen;
    bit busy_bad;
    @(negedge clk);
    op = t_op; din = t_din; amt = t_amt; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); din = 8'($urandom); amt = 3'($urandom);
    cyc = 0; seen = 1'b0; busy_bad = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (busy !== 1'b1) busy_bad = 1'b1;
    end
    n_vec++;
    if (!seen || cyc != int'(t_amt) + 1) begin
      n_err++;
      $display("FAIL latency op=%0d amt=%0d: got %0d cycles (seen=%0b), want %0d", t_op, t_amt, cyc, seen, int'(t_amt) + 1);
    end
    n_vec++;
    if (dout !== exp_d) begin
      n_err++;
      $display("FAIL dout op=%0d din=%h amt=%0d: got %h, want %h", t_op, t_din, t_amt, dout, exp_d);
    end
    n_vec++;
    if (ovf !== exp_o) begin
      n_err++;
      $display("FAIL ovf op=%0d din=%h amt=%0d: got %b, want %b", t_op, t_din, t_amt, ovf, exp_o);
    end
    n_vec++;
    if (busy_bad || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy op=%0d amt=%0d: low during shift=%0b, busy at done=%b, want 1/0", t_op, t_amt, busy_bad, busy);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || dout !== exp_d || ovf !== exp_o) begin
      n_err++;
      $display("FAIL hold op=%0d: done=%b dout=%h ovf=%b, want 0 %h %b", t_op, done, dout, ovf, exp_d, exp_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; din = '0; amt = '0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b dout=%h ovf=%b, want 0 0 00 0", busy, done, dout, ovf);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_release idle: busy=%b done=%b dout=%h, want 0 0 00", busy, done, dout);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 8'h81, 3'd3, 8'h08, 1'b1);
    run_op(3'd2, 8'h90, 3'd2, 8'hE4, 1'b0);
    run_op(3'd1, 8'h90, 3'd2, 8'h24, 1'b0);
    run_op(3'd4, 8'h01, 3'd1, 8'h80, 1'b0);
    run_op(3'd3, 8'h80, 3'd7, 8'h40, 1'b0);
    run_op(3'd5, 8'h40, 3'd1, 8'h80, 1'b1);
    run_op(3'd5, 8'h20, 3'd1, 8'h40, 1'b0);
    run_op(3'd6, 8'h5A, 3'd4, 8'h5A, 1'b0);
    run_op(3'd7, 8'hA5, 3'd7, 8'hA5, 1'b0);
    run_op(3'd1, 8'hC3, 3'd0, 8'hC3, 1'b0);
    run_op(3'd0, 8'hFF, 3'd0, 8'hFF, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] r_op;
    logic [7:0] r_din;
    logic [2:0] r_amt;
    logic [7:0] e_d;
    bit e_o;
    for (int i = 0; i < 40; i++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_din = 8'($urandom);
      r_amt = 3'($urandom_range(0, 7));
      model(r_op, r_din, int'(r_amt), e_d, e_o);
      run_op(r_op, r_din, r_amt, e_d, e_o);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    @(negedge clk);
    op = 3'd1; din = 8'hF0; amt = 3'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    n_vec++;
    if (!seen || dout !== 8'h3C) begin
      n_err++;
      $display("FAIL b2b_first: seen=%0b dout=%h, want 1 3c", seen, dout);
    end
    // Start asserted during the DONE cycle must be accepted.
    op = 3'd3; din = 8'h81; amt = 3'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    n_vec++;
    if (!seen || cyc != 4 || dout !== 8'h0C || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: seen=%0b cycles=%0d dout=%h ovf=%b, want 1 4 0c 0", seen, cyc, dout, ovf);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    int done_at;
    logic [7:0] d_at;
    bit o_at;
    @(negedge clk);
    op = 3'd0; din = 8'h81; amt = 3'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; done_at = -1; d_at = '0; o_at = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++; done_at = i; d_at = dout; o_at = ovf;
      end
      start = (i == 1 || i == 2);
      op = 3'd4; din = 8'h55; amt = 3'd1;
    end
    n_vec++;
    if (ndone != 1 || done_at != 5) begin
      n_err++;
      $display("FAIL busy_ignore dones: count=%0d at=%0d, want 1 at 5", ndone, done_at);
    end
    n_vec++;
    if (d_at !== 8'h20 || o_at !== 1'b1) begin
      n_err++;
      $display("FAIL busy_ignore result: dout=%h ovf=%b, want 20 1", d_at, o_at);
    end
  endtask

  task automatic test_reset_mid_shift();
    int ndone;
    @(negedge clk);
    op = 3'd0; din = 8'hFF; amt = 3'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL pre_abort: busy=%b ovf=%b, want 1 1", busy, ovf);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL abort: busy=%b done=%b dout=%h ovf=%b, want 0 0 00 0", busy, done, dout, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_vec++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL abort_no_done: active cycles=%0d, want 0", ndone);
    end
    run_op(3'd0, 8'h81, 3'd3, 8'h08, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle, parametrised shift/rotate unit with a start/done handshake. It replaces the fixed 4-bit combinational shifter in the datapath. It supports logical, arithmetic and rotate operations on a WIDTH-bit operand by a variable amount, moving one bit position per clock. Overflow is reported for the left-shift modes.

## Interface
- WIDTH, 8: operand/result width; must be ≥ 2.
- AMT_W, $clog2(WIDTH): width of the shift-amount port.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- op  in  3  operation code, captured with start.
- din  in  WIDTH  operand, captured with start.
- amt  in  AMT_W  shift amount 0..WIDTH-1, captured with start.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse when dout/ovf are valid.
- dout  out  WIDTH  result; held until the next accepted start.
- ovf  out  1  overflow flag for the current result; held with dout.

## Operation
- Op codes:
  - 000 SLL (zero fill).
  - 001 SRL (zero fill).
  - 010 SRA (sign fill).
  - 011 ROL.
  - 100 ROR.
  - 101 ASL (zero fill, signed overflow detect).
  - 110/111 reserved: the result is din unchanged and ovf=0, with normal amt-cycle latency.
- FSM states: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 (accept):
  - Load the working register from din, the counter from amt, and latch op.
  - Clear ovf.
  - Next state is SHIFT if amt≠0, else DONE.
- SHIFT:
  - Each edge applies one single-bit step of the latched op and decrements the counter.
  - When the counter reaches 0 after the step, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is IDLE, or a new accept if start=1 in that cycle.
- dout is the working register. It is only updated by accept/shift, so the final value holds after done.
- ovf rules:
  - SLL: sticky-set if any shifted-out bit is 1.
  - ASL: sticky-set if the MSB changes on any step.
  - All other ops: 0.
- start while busy=1 is ignored and not queued. op, din and amt changes during SHIFT have no effect.
- amt never exceeds WIDTH-1 by width when WIDTH is a power of two. For a non-power-of-two WIDTH, amt ≥ WIDTH is clamped to WIDTH-1.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, dout=0, ovf=0, counter=0.
- Start sampled at edge 0 → done high in the cycle after edge amt, i.e. latency amt+1 cycles. amt=0 gives done one cycle after start.
- busy is high from the edge after accept through the edge entering DONE. busy=0 during DONE and IDLE.
- Back-to-back: start in the DONE cycle is accepted, giving throughput of one op per amt+1 cycles.
- Reset mid-SHIFT:
  - Abort immediately; outputs take their reset values.
  - No done pulse is produced for the aborted op.
- A simultaneous start and rst is lost to reset.

## Structure
- Package shifter_pkg holds:
  - op code localparams (OP_SLL … OP_ASL).
  - FSM state enum {IDLE, SHIFT, DONE}.
- Sub-module shift_step:
  - Combinational single-bit step: inputs are the value and op; outputs are the next value and the step overflow bit.
  - Instantiated once, driving the working register.
- The top level holds the FSM, counter, working register and sticky ovf.

## Test plan
- WIDTH=8, SLL 0x81 amt=3 → done 4 cycles after start, dout=0x08, ovf=1.
- SRA 0x90 amt=2 → dout=0xE4, ovf=0. SRL 0x90 amt=2 → dout=0x24.
- ROR 0x01 amt=1 → dout=0x80. ROL 0x80 amt=7 → dout=0x40. Both ovf=0.
- ASL 0x40 amt=1 → dout=0x80, ovf=1. ASL 0x20 amt=1 → dout=0x40, ovf=0.
- amt=0 with any op → done one cycle after start, dout=din. A second start pulsed in the DONE cycle is accepted. A start pulsed while busy is ignored, and only one done is produced per accept.
- Assert rst during SHIFT of SLL 0xFF amt=5 → busy=0, dout=0, ovf=0 immediately, and no done. A fresh op after release completes normally.
